// File: rtl/unary_pkg.sv
// Shared types, defaults and the thermometer-encode helper for the unary
// frame driver and its unary-stream decoder.
package unary_pkg;

    localparam int VAL_W_DEF     = 4;
    localparam int FRAME_LEN_DEF = 15;
    localparam int DRAIN_LEN_DEF = 32;
    localparam int SUM_W_DEF     = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Leading-ones thermometer code: bit k of the stream for value v.
    function automatic logic therm(input logic [31:0] k, input logic [31:0] v);
        return (k < v);
    endfunction

endpackage

// File: rtl/unary_count_dec.sv
// Saturating 1s counter: decodes a unary stream into a binary count.
// An increment attempted at the maximum count sets a sticky overflow flag.
module unary_count_dec #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] count,
    output logic         ovf
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (en && din) begin
            if (count == '1) begin
                ovf <= 1'b1;
            end else begin
                count <= count + W'(1);
            end
        end
    end

endmodule

// File: rtl/unary_frame_driver.sv
// Serialises two binary operands into unary frames for the serial adder,
// then decodes the adder's unary result back into a binary sum.
module unary_frame_driver
    import unary_pkg::*;
#(
    parameter int VAL_W     = VAL_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int DRAIN_LEN = DRAIN_LEN_DEF,
    parameter int SUM_W     = SUM_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAL_W-1:0] a_val,
    input  logic [VAL_W-1:0] b_val,
    output logic             A,
    output logic             B,
    output logic             en,
    output logic             read_or_write,
    input  logic             dout,
    input  logic             C,
    output logic [SUM_W-1:0] sum,
    output logic             sum_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int K_MAX = (FRAME_LEN > DRAIN_LEN) ? FRAME_LEN : DRAIN_LEN;
    localparam int K_W   = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    state_t           state;
    logic [K_W-1:0]   k;
    logic [VAL_W-1:0] a_q;
    logic [VAL_W-1:0] b_q;
    logic             c_ovf;
    logic             accept;
    logic             cnt_en;
    logic             cnt_ovf;
    logic [SUM_W-1:0] cnt;

    assign accept = (state == IDLE) && in_valid && in_ready;
    assign cnt_en = (state == DRAIN);

    unary_count_dec #(.W(SUM_W)) u_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (cnt_en),
        .din   (dout),
        .count (cnt),
        .ovf   (cnt_ovf)
    );

    assign sum     = cnt;
    assign sum_ovf = cnt_ovf | c_ovf;

    // k always indexes the cycle whose A/B/en values are currently on the outputs,
    // so each transition precomputes the stream bits for the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            k             <= '0;
            a_q           <= '0;
            b_q           <= '0;
            A             <= 1'b0;
            B             <= 1'b0;
            en            <= 1'b0;
            read_or_write <= 1'b0;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            c_ovf         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q           <= a_val;
                        b_q           <= b_val;
                        k             <= '0;
                        c_ovf         <= 1'b0;
                        A             <= therm(32'd0, 32'(a_val));
                        B             <= therm(32'd0, 32'(b_val));
                        en            <= 1'b1;
                        read_or_write <= 1'b0;
                        in_ready      <= 1'b0;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (C) c_ovf <= 1'b1;
                    if (k == K_W'(FRAME_LEN - 1)) begin
                        k             <= '0;
                        A             <= 1'b0;
                        B             <= 1'b0;
                        read_or_write <= 1'b1;
                        state         <= DRAIN;
                    end else begin
                        k <= k + K_W'(1);
                        A <= therm(32'(k) + 32'd1, 32'(a_q));
                        B <= therm(32'(k) + 32'd1, 32'(b_q));
                    end
                end
                DRAIN: begin
                    if (C) c_ovf <= 1'b1;
                    if (k == K_W'(DRAIN_LEN - 1)) begin
                        k             <= '0;
                        en            <= 1'b0;
                        read_or_write <= 1'b0;
                        out_valid     <= 1'b1;
                        state         <= RESP;
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/unary_frame_driver.md
Name: unary_frame_driver

Overview:
- Transmit/receive end for the serial unary adder datapath.
- Accepts two binary operands over a valid/ready handshake and serialises each as a thermometer-coded unary stream (A, B) framed by en, with read_or_write held low.
- Then switches the adder to write mode (read_or_write=1), counts the 1s the adder returns on dout, and presents the binary sum with an overflow flag on a second valid/ready handshake.

Parameters:
- VAL_W, 4: operand width in bits; operand range 0..2^VAL_W-1.
- FRAME_LEN, 15: read-phase length in cycles; must be >= 2^VAL_W-1.
- DRAIN_LEN, 32: write-phase length in cycles; covers the largest sum plus the adder's output latency.
- SUM_W, 6: result width; 2^SUM_W-1 must be >= DRAIN_LEN for a non-saturating configuration.

Ports:
- clk, input, 1: clock; all logic on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- in_valid, input, 1: operand pair valid.
- in_ready, output, 1: block can accept operands.
- a_val, input, VAL_W: operand A, binary.
- b_val, input, VAL_W: operand B, binary.
- A, output, 1: unary stream A to the adder.
- B, output, 1: unary stream B to the adder.
- en, output, 1: adder enable, frame strobe.
- read_or_write, output, 1: 0 = adder reads A/B; 1 = adder writes its count on dout.
- dout, input, 1: unary result stream from the adder.
- C, input, 1: adder carry/overflow indication.
- sum, output, SUM_W: decoded binary result.
- sum_ovf, output, 1: result saturated, or C was seen during the frame.
- out_valid, output, 1: sum/sum_ovf valid.
- out_ready, input, 1: consumer accepts the result.

Behaviour:
- Reset (rst_n=0 sampled at an edge):
  - State goes to IDLE.
  - A=B=en=read_or_write=0, out_valid=0, sum=0, sum_ovf=0, in_ready=1 from the following cycle.
  - Reset mid-frame aborts the frame. No partial result is presented.
- States: IDLE -> SEND -> DRAIN -> RESP -> IDLE.
- IDLE:
  - in_ready=1, en=0.
  - On in_valid&in_ready, latch a_val->a_q and b_val->b_q, clear the phase counter, clear the sum accumulator and ovf, then go to SEND.
- SEND (FRAME_LEN cycles, phase counter k=0..FRAME_LEN-1):
  - en=1, read_or_write=0.
  - A=(k<a_q), B=(k<b_q). Leading-ones thermometer code; a_q=0 gives an all-zero stream.
  - in_ready=0.
  - After the last cycle, go to DRAIN with k=0.
- DRAIN (DRAIN_LEN cycles):
  - en=1, read_or_write=1, A=B=0.
  - At each edge in DRAIN, if dout=1, the accumulator increments.
  - The accumulator saturates at 2^SUM_W-1. An increment attempted at the maximum sets ovf.
  - C=1 sampled at any edge in SEND or DRAIN sets ovf (sticky).
  - After the last cycle, go to RESP.
- RESP:
  - en=0, read_or_write=0.
  - out_valid=1; sum and sum_ovf are driven from registers and stay stable while out_valid=1 && out_ready=0.
  - The transfer completes at an edge where out_valid&out_ready; the next state is IDLE.
- Outputs A, B, en and read_or_write are registered: each reflects the state of the current cycle, with no combinational path from inputs.
- Minimum gap: at least one en=0 cycle (IDLE) between consecutive frames, so the adder sees frame boundaries.
- Throughput: one operation per 1+FRAME_LEN+DRAIN_LEN+1 cycles minimum.
- in_valid is ignored outside IDLE; the operand source must hold it until in_ready.
- Operand values above FRAME_LEN cannot occur under the parameter constraint. Any excess is truncated by the frame length.

Decomposition:
- Shared package unary_pkg holds:
  - the state enum (IDLE, SEND, DRAIN, RESP);
  - the thermometer-encode helper function;
  - default constants for VAL_W, FRAME_LEN and DRAIN_LEN.
- One natural sub-module: unary_count_dec, a saturating 1s counter with clear, enable, bit input, and count/ovf outputs. It is reusable wherever a unary stream must be decoded.

Test Plan:
- The bench pairs the block with a behavioural unary-adder model:
  - it counts 1s on A and B while en&~read_or_write;
  - it emits that many 1s on dout, one cycle after write mode begins.
- Scenarios:
  1. a_val=3, b_val=5, out_ready=1 -> A high exactly 3 SEND cycles, B high 5; sum=8, sum_ovf=0; out_valid after 1+15+32+1 cycles.
  2. a_val=0, b_val=0 -> A=B=0 throughout SEND; sum=0, sum_ovf=0.
  3. a_val=15, b_val=15 -> sum=30, sum_ovf=0.
  4. Back-pressure: out_ready low for 5 cycles in RESP -> sum/out_valid held stable, in_ready=0; the next in_valid is accepted only after the handshake.
  5. Overflow: with DRAIN_LEN=70 and a model that holds dout=1 -> sum=63, sum_ovf=1. Separately, C pulsed once in DRAIN -> sum_ovf=1 with the correct sum.
  6. rst_n=0 for one edge in mid-SEND -> next cycle en=A=B=0, out_valid=0, in_ready=1; a fresh 2+2 op then yields sum=4.
